tridiag_det_host: RTL and testbench

- Initiator-side controller for the tridiagonal determinant engine.
- Collects matrix coefficients one word at a time over a valid/ready write port and holds them in internal registers. The registers drive the engine's flattened a/b/c buses.
- On a go command it runs the start/done/ack handshake with the engine, captures det and returns it on a valid/ready result port.
- Sits between the system bus adapter and the engine. Includes a watchdog so a hung engine cannot stall the bus.

---
 rtl/tridiag_det_host.sv | 162 ++++++++++++++++
 tb/tb_tridiag_det_host.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tridiag_det_host.sv
// Host-side controller for the tridiagonal determinant engine: coefficient
// register file, start/done/ack sequencing, watchdog and a valid/ready result port.
module tridiag_det_host #(
   parameter int unsigned N       = 16,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [1:0]             wr_sel,
   input  logic [3:0]             wr_idx,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   go_valid,
   output logic                   go_ready,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [2*WIDTH-1:0]     res_det,
   output logic                   res_err,
   output logic                   idx_err,
   output logic [WIDTH*(N-1)-1:0] a_flat,
   output logic [WIDTH*N-1:0]     b_flat,
   output logic [WIDTH*(N-1)-1:0] c_flat,
   output logic                   start,
   output logic                   ack,
   input  logic                   done,
   input  logic [2*WIDTH-1:0]     det
);

   typedef enum logic [2:0] {IDLE, START, WAIT, ACK, RESP} state_t;

   localparam int unsigned     WD_W     = $clog2(TIMEOUT);
   // Abort point chosen so res_valid rises exactly TIMEOUT cycles after the start pulse.
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 3);
   localparam logic [4:0]      AC_MAX   = 5'(N - 2);
   localparam logic [4:0]      B_MAX    = 5'(N - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q [N-1];
   logic [WIDTH-1:0]     a_d [N-1];
   logic [WIDTH-1:0]     b_q [N];
   logic [WIDTH-1:0]     b_d [N];
   logic [WIDTH-1:0]     c_q [N-1];
   logic [WIDTH-1:0]     c_d [N-1];
   logic [WD_W-1:0]      wd_q, wd_d;
   logic [2*WIDTH-1:0]   res_det_q, res_det_d;
   logic                 res_err_q, res_err_d;
   logic                 idx_err_q, idx_err_d;
   logic                 wr_fire, go_fire, wr_bad;

   always_comb begin
      wr_ready  = (state_q == IDLE);
      go_ready  = (state_q == IDLE) && !done;
      wr_fire   = wr_valid && wr_ready;
      go_fire   = go_valid && go_ready;
      start     = (state_q == START);
      ack       = (state_q == ACK);
      res_valid = (state_q == RESP);
      res_det   = res_det_q;
      res_err   = res_err_q;
      idx_err   = idx_err_q;
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      wr_bad = 1'b0;
      if (wr_fire) begin
         case (wr_sel)
            2'd0: begin
               if ({1'b0, wr_idx} > AC_MAX) wr_bad = 1'b1;
               for (int unsigned k = 0; k < N - 1; k++)
                  if (wr_idx == 4'(k)) a_d[k] = wr_data;
            end
            2'd1: begin
               if ({1'b0, wr_idx} > B_MAX) wr_bad = 1'b1;
               for (int unsigned k = 0; k < N; k++)
                  if (wr_idx == 4'(k)) b_d[k] = wr_data;
            end
            2'd2: begin
               if ({1'b0, wr_idx} > AC_MAX) wr_bad = 1'b1;
               for (int unsigned k = 0; k < N - 1; k++)
                  if (wr_idx == 4'(k)) c_d[k] = wr_data;
            end
            default: wr_bad = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      res_det_d = res_det_q;
      res_err_d = res_err_q;
      idx_err_d = idx_err_q;
      // A dropped write in the launch cycle still gets reported.
      if (go_fire) idx_err_d = 1'b0;
      if (wr_bad)  idx_err_d = 1'b1;
      case (state_q)
         IDLE:  if (go_fire) state_d = START;
         START: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + 1'b1;
            if (done) begin
               res_det_d = det;
               res_err_d = 1'b0;
               state_d   = ACK;
            end else if (wd_q == WD_LIMIT) begin
               res_det_d = '0;
               res_err_d = 1'b1;
               state_d   = ACK;
            end
         end
         ACK:     if (!done) state_d = RESP;
         RESP:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_flat = '0;
      b_flat = '0;
      c_flat = '0;
      for (int unsigned k = 0; k < N - 1; k++) begin
         a_flat[k*WIDTH +: WIDTH] = a_q[k];
         c_flat[k*WIDTH +: WIDTH] = c_q[k];
      end
      for (int unsigned k = 0; k < N; k++)
         b_flat[k*WIDTH +: WIDTH] = b_q[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wd_q      <= '0;
         res_det_q <= '0;
         res_err_q <= 1'b0;
         idx_err_q <= 1'b0;
         for (int unsigned k = 0; k < N - 1; k++) begin
            a_q[k] <= '0;
            c_q[k] <= '0;
         end
         for (int unsigned k = 0; k < N; k++)
            b_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         res_det_q <= res_det_d;
         res_err_q <= res_err_d;
         idx_err_q <= idx_err_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
      end
   end

endmodule

// File: tb/tb_tridiag_det_host.sv
// Bench for tridiag_det_host: behavioural engine stub on the flat buses plus a
// coefficient-level determinant model fed from the bench's own shadow copy.
module tb_tridiag_det_host;
   localparam int unsigned N  = 4;
   localparam int unsigned W  = 16;
   localparam int unsigned TO = 20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_valid = 1'b0, wr_ready;
   logic [1:0]       wr_sel = '0;
   logic [3:0]       wr_idx = '0;
   logic [W-1:0]     wr_data = '0;
   logic             go_valid = 1'b0, go_ready;
   logic             res_valid, res_ready = 1'b0;
   logic [2*W-1:0]   res_det;
   logic             res_err, idx_err;
   logic [W*(N-1)-1:0] a_flat, c_flat;
   logic [W*N-1:0]   b_flat;
   logic             start, ack;
   logic             done = 1'b0;
   logic [2*W-1:0]   det = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tridiag_det_host #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
      .go_valid(go_valid), .go_ready(go_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_det(res_det), .res_err(res_err),
      .idx_err(idx_err), .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
      .start(start), .ack(ack), .done(done), .det(det)
   );

   // Shadow coefficients: what the host registers should hold.
   logic signed [W-1:0] sa [N-1];
   logic signed [W-1:0] sb [N];
   logic signed [W-1:0] sc [N-1];

   function automatic logic [2*W-1:0] model_det();
      longint p2, p1, f;
      p2 = 1;
      p1 = longint'(sb[0]);
      for (int k = 1; k < N; k++) begin
         f  = longint'(sb[k]) * p1 - longint'(sa[k-1]) * longint'(sc[k-1]) * p2;
         p2 = p1;
         p1 = f;
      end
      return p1[2*W-1:0];
   endfunction

   // Engine stub: samples the buses at the start edge, raises done N+1 cycles
   // later and keeps it one cycle after it sees ack.
   logic hang = 1'b0;
   logic eng_busy = 1'b0, eng_seen = 1'b0;
   int   eng_cnt = 0;

   function automatic logic [2*W-1:0] eng_compute();
      longint p2, p1, f;
      p2 = 1;
      p1 = longint'($signed(b_flat[0 +: W]));
      for (int k = 1; k < N; k++) begin
         f = longint'($signed(b_flat[k*W +: W])) * p1
           - longint'($signed(a_flat[(k-1)*W +: W])) * longint'($signed(c_flat[(k-1)*W +: W])) * p2;
         p2 = p1;
         p1 = f;
      end
      return p1[2*W-1:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0; det <= '0; eng_busy <= 1'b0; eng_seen <= 1'b0; eng_cnt <= 0;
      end else begin
         if (start && !hang) begin
            eng_busy <= 1'b1; eng_cnt <= N; det <= eng_compute();
         end else if (eng_busy) begin
            if (eng_cnt == 1) begin eng_busy <= 1'b0; done <= 1'b1; end
            eng_cnt <= eng_cnt - 1;
         end
         if (done && ack) eng_seen <= 1'b1;
         if (eng_seen) begin done <= 1'b0; eng_seen <= 1'b0; end
      end
   end

   task automatic put(input logic [1:0] sel, input logic [3:0] idx, input logic [W-1:0] data);
      case (sel)
         2'd0: if (idx <= N - 2) sa[idx] = data;
         2'd1: if (idx <= N - 1) sb[idx] = data;
         2'd2: if (idx <= N - 2) sc[idx] = data;
         default: ;
      endcase
      @(negedge clk);
      wr_valid = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = data;
      @(posedge clk);
      #1 wr_valid = 1'b0;
   endtask

   task automatic fill(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv);
      for (int i = 0; i < N; i++) begin
         put(2'd1, 4'(i), bv);
         if (i < N - 1) begin
            put(2'd0, 4'(i), av);
            put(2'd2, 4'(i), cv);
         end
      end
   endtask

   // Launch and run until res_valid; records start pulses, ack cycles and latency.
   task automatic do_go(output logic [2*W-1:0] d_o, output logic e_o, output int lat_o,
                        output int ackc_o, output int stc_o);
      bit seen_start = 0;
      bit got = 0;
      lat_o = 0; ackc_o = 0; stc_o = 0;
      @(negedge clk);
      go_valid = 1'b1;
      @(posedge clk);
      #1 go_valid = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (start) begin stc_o++; seen_start = 1; end
         if (ack) ackc_o++;
         checks++;
         if ((start && ack) || (start && done) || (ackc_o > 0 && !ack && done && !res_valid)) begin
            failures++;
            $display("FAIL handshake: start=%0b ack=%0b done=%0b (required no overlap, ack held while done)", start, ack, done);
         end
         if (res_valid) begin got = 1; break; end
         if (seen_start) lat_o++;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL res_valid_timeout: res_valid=%0b required 1 within 300 cycles", res_valid);
      end
      d_o = res_det; e_o = res_err;
   endtask

   task automatic consume();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || wr_ready !== 1'b1) begin
         failures++;
         $display("FAIL release: res_valid=%0b wr_ready=%0b required 0/1", res_valid, wr_ready);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         sb[i] = '0;
         if (i < N - 1) begin sa[i] = '0; sc[i] = '0; end
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({start, ack, res_valid, res_err, idx_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: start/ack/res_valid/res_err/idx_err=%05b required 00000",
                  {start, ack, res_valid, res_err, idx_err});
      end
      checks++;
      if (res_det !== '0 || a_flat !== '0 || b_flat !== '0 || c_flat !== '0) begin
         failures++;
         $display("FAIL reset_data: res_det=%h a=%h b=%h c=%h required all 0", res_det, a_flat, b_flat, c_flat);
      end
      checks++;
      if (wr_ready !== 1'b1 || go_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: wr_ready=%0b go_ready=%0b required 1/1", wr_ready, go_ready);
      end
   endtask

   task automatic test_det5();
      logic [2*W-1:0] d; logic e; int lat, ackc, stc;
      fill(16'd1, 16'd2, 16'd1);
      @(negedge clk);
      checks++;
      if (a_flat !== 48'h0001_0001_0001 || b_flat !== 64'h0002_0002_0002_0002 || c_flat !== 48'h0001_0001_0001) begin
         failures++;
         $display("FAIL det5_buses: a=%h b=%h c=%h required 000100010001/0002000200020002/000100010001", a_flat, b_flat, c_flat);
      end
      do_go(d, e, lat, ackc, stc);
      checks++;
      if (stc !== 1) begin failures++; $display("FAIL det5_start_pulse: cycles=%0d required 1", stc); end
      checks++;
      if (d !== 32'd5 || e !== 1'b0) begin
         failures++; $display("FAIL det5_result: det=%0d err=%0b required 5/0", $signed(d), e);
      end
      checks++;
      if (ackc < 2) begin failures++; $display("FAIL det5_ack_len: cycles=%0d required >=2", ackc); end
      consume();
   endtask

   task automatic test_diag81();
      logic [2*W-1:0] d; logic e; int lat, ackc, stc;
      fill(16'd0, 16'd3, 16'd0);
      for (int r = 0; r < 2; r++) begin
         do_go(d, e, lat, ackc, stc);
         checks++;
         if (d !== 32'd81 || e !== 1'b0) begin
            failures++; $display("FAIL diag81_run%0d: det=%0d err=%0b required 81/0", r, $signed(d), e);
         end
         consume();
      end
   endtask

   task automatic test_signed();
      logic [2*W-1:0] d, exp_d; logic e; int lat, ackc, stc;
      fill(16'd0, 16'hFFFF, 16'd0);
      do_go(d, e, lat, ackc, stc);
      checks++;
      if (d !== 32'd1) begin failures++; $display("FAIL neg_ones: det=%h required 00000001", d); end
      consume();
      put(2'd1, 4'd0, 16'hFFFE);
      exp_d = model_det();
      @(negedge clk);
      checks++;
      if (b_flat[15:0] !== 16'hFFFE) begin failures++; $display("FAIL raw_b0: b0=%h required fffe", b_flat[15:0]); end
      do_go(d, e, lat, ackc, stc);
      checks++;
      if (d !== exp_d) begin failures++; $display("FAIL neg_b0: det=%h required %h", d, exp_d); end
      consume();
   endtask

   task automatic test_idx_err();
      logic [2*W-1:0] d, exp_d; logic e; int lat, ackc, stc;
      logic [W*(N-1)-1:0] a0, c0; logic [W*N-1:0] b0;
      @(negedge clk);
      a0 = a_flat; b0 = b_flat; c0 = c_flat;
      put(2'd0, 4'd3, 16'h1234);
      put(2'd3, 4'd0, 16'h5678);
      put(2'd1, 4'd4, 16'h9ABC);
      put(2'd2, 4'd15, 16'h0F0F);
      @(negedge clk);
      checks++;
      if (idx_err !== 1'b1) begin failures++; $display("FAIL idx_err_set: idx_err=%0b required 1", idx_err); end
      checks++;
      if (a_flat !== a0 || b_flat !== b0 || c_flat !== c0) begin
         failures++; $display("FAIL idx_drop: a=%h b=%h c=%h required %h %h %h", a_flat, b_flat, c_flat, a0, b0, c0);
      end
      exp_d = model_det();
      do_go(d, e, lat, ackc, stc);
      checks++;
      if (idx_err !== 1'b0 || d !== exp_d) begin
         failures++; $display("FAIL idx_err_clear: idx_err=%0b det=%h required 0 %h", idx_err, d, exp_d);
      end
      consume();
   endtask

   task automatic test_random();
      logic [2*W-1:0] d, exp_d; logic e; int lat, ackc, stc;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < N; i++) begin
            put(2'd1, 4'(i), W'(int'($urandom_range(15)) - 8));
            if (i < N - 1) begin
               put(2'd0, 4'(i), W'(int'($urandom_range(15)) - 8));
               put(2'd2, 4'(i), W'(int'($urandom_range(15)) - 8));
            end
         end
         exp_d = model_det();
         do_go(d, e, lat, ackc, stc);
         checks++;
         if (d !== exp_d || e !== 1'b0) begin
            failures++; $display("FAIL random_%0d: det=%h err=%0b required %h/0", it, d, e, exp_d);
         end
         consume();
      end
   endtask

   task automatic test_timeout();
      logic [2*W-1:0] d; logic e; int lat, ackc, stc;
      hang = 1'b1;
      do_go(d, e, lat, ackc, stc);
      hang = 1'b0;
      checks++;
      if (d !== '0 || e !== 1'b1) begin
         failures++; $display("FAIL timeout_result: det=%h err=%0b required 0/1", d, e);
      end
      checks++;
      if (lat !== TO) begin failures++; $display("FAIL timeout_latency: cycles=%0d required %0d", lat, TO); end
      checks++;
      if (ackc !== 1) begin failures++; $display("FAIL timeout_ack_len: cycles=%0d required 1", ackc); end
      consume();
   endtask

   task automatic test_hold_stall();
      logic [2*W-1:0] d, exp_d; logic e; int lat, ackc, stc;
      exp_d = model_det();
      do_go(d, e, lat, ackc, stc);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_det !== exp_d || res_err !== 1'b0 || wr_ready !== 1'b0 || go_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_%0d: valid=%0b det=%h err=%0b wr_ready=%0b go_ready=%0b required 1 %h 0 0 0",
                     i, res_valid, res_det, res_err, wr_ready, go_ready, exp_d);
         end
      end
      consume();
   endtask

   task automatic test_reset_mid();
      hang = 1'b1;
      @(negedge clk);
      go_valid = 1'b1;
      @(posedge clk);
      #1 go_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ack !== 1'b0 || res_valid !== 1'b0 || wr_ready !== 1'b0) begin
         failures++; $display("FAIL mid_wait: ack=%0b res_valid=%0b wr_ready=%0b required 0 0 0", ack, res_valid, wr_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({start, ack, res_valid, res_err, idx_err} !== 5'b0 || res_det !== '0 || b_flat !== '0 || a_flat !== '0) begin
         failures++;
         $display("FAIL async_reset: ctl=%05b det=%h a=%h b=%h required 0", {start, ack, res_valid, res_err, idx_err},
                  res_det, a_flat, b_flat);
      end
      checks++;
      if (wr_ready !== 1'b1 || go_ready !== 1'b1) begin
         failures++; $display("FAIL async_reset_ready: wr_ready=%0b go_ready=%0b required 1/1", wr_ready, go_ready);
      end
      hang = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_det5();
      test_diag81();
      test_signed();
      test_idx_err();
      test_random();
      test_timeout();
      test_hold_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
